// File: rtl/dmem_monitor_pkg.sv
// Shared types and constants for the data-memory pass/fail monitor.
package dmem_monitor_pkg;

  localparam int unsigned DEF_DEPTH       = 64;
  localparam int unsigned DEF_PASS_ADR    = 100;
  localparam int unsigned DEF_PASS_DATA   = 7;
  localparam int unsigned DEF_SCRATCH_ADR = 96;
  localparam int unsigned DEF_TIMEOUT     = 1024;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned WD_W   = 32;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

  localparam logic [1:0] STATUS_RUN     = 2'b00;
  localparam logic [1:0] STATUS_PASS    = 2'b01;
  localparam logic [1:0] STATUS_FAIL    = 2'b10;
  localparam logic [1:0] STATUS_TIMEOUT = 2'b11;

endpackage

// File: rtl/dmem_ram.sv
// Word-addressed data RAM: asynchronous read, synchronous write, no reset.
module dmem_ram
  import dmem_monitor_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_monitor.sv
// Data memory plus a store-watching monitor that decides pass/fail/timeout
// for a self-checking CPU program.
module dmem_monitor
  import dmem_monitor_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned PASS_ADR    = DEF_PASS_ADR,
  parameter int unsigned PASS_DATA   = DEF_PASS_DATA,
  parameter int unsigned SCRATCH_ADR = DEF_SCRATCH_ADR,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite,
  input  logic [DATA_W-1:0] DataAdr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Done,
  output logic              Pass,
  output logic [1:0]        Status,
  output logic [CNT_W-1:0]  StoreCount
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e            state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              in_range_c;
  logic [AW-1:0]     idx_c;
  logic [DATA_W-1:0] ram_rdata;
  logic              pass_store_c;
  logic              fail_store_c;
  logic              wd_expire_c;

  // Address decode: word-aligned and inside the RAM window.
  always_comb begin
    in_range_c = (DataAdr[DATA_W-1:AW+2] == '0) && (DataAdr[1:0] == 2'b00);
    idx_c      = DataAdr[AW+1:2];
  end

  dmem_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (MemWrite && in_range_c),
    .addr  (idx_c),
    .wdata (WriteData),
    .rdata (ram_rdata)
  );

  always_comb begin
    ReadData = in_range_c ? ram_rdata : '0;
  end

  // Store classification and watchdog expiry for the current edge.
  always_comb begin
    pass_store_c = MemWrite && (DataAdr == DATA_W'(PASS_ADR))
                   && (WriteData == DATA_W'(PASS_DATA));
    fail_store_c = MemWrite && !pass_store_c
                   && (DataAdr != DATA_W'(SCRATCH_ADR));
    wd_expire_c  = (wd_q == WD_W'(TIMEOUT - 1));
  end

  // State register, watchdog and store counter.
  always_ff @(posedge clk) begin
    state_q <= state_d;
    wd_q    <= wd_d;
    cnt_q   <= cnt_d;
  end

  // Next state: store decisions take priority over watchdog expiry.
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    cnt_d   = cnt_q;
    if (reset) begin
      state_d = ST_RUN;
      wd_d    = '0;
      cnt_d   = '0;
    end else if (state_q == ST_RUN) begin
      wd_d = wd_q + WD_W'(1);
      if (MemWrite && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (pass_store_c) begin
        state_d = ST_PASS;
      end else if (fail_store_c) begin
        state_d = ST_FAIL;
      end else if (wd_expire_c) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  // Outputs decoded from the state register only.
  always_comb begin
    Done   = 1'b0;
    Pass   = 1'b0;
    Status = STATUS_RUN;
    case (state_q)
      ST_PASS: begin
        Done   = 1'b1;
        Pass   = 1'b1;
        Status = STATUS_PASS;
      end
      ST_FAIL: begin
        Done   = 1'b1;
        Status = STATUS_FAIL;
      end
      ST_TIMEOUT: begin
        Done   = 1'b1;
        Status = STATUS_TIMEOUT;
      end
      default: ;
    endcase
  end

  assign StoreCount = cnt_q;

endmodule

// File: tb/tb_dmem_monitor.sv
// Self-checking bench for dmem_monitor: directed scenarios plus randomized
// store/load traffic compared against a behavioural model.
module tb_dmem_monitor;

  localparam int unsigned TB_DEPTH   = 64;
  localparam int unsigned TB_TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Done;
  logic        Pass;
  logic [1:0]  Status;
  logic [15:0] StoreCount;

  int checks;
  int failures;

  // Behavioural model: status 0=RUN 1=PASS 2=FAIL 3=TIMEOUT.
  int          m_status;
  int          m_run_edges;
  int          m_stores;
  logic [31:0] m_mem   [TB_DEPTH];
  bit          m_known [TB_DEPTH];

  dmem_monitor #(
    .DEPTH       (TB_DEPTH),
    .PASS_ADR    (100),
    .PASS_DATA   (7),
    .SCRATCH_ADR (96),
    .TIMEOUT     (TB_TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Done       (Done),
    .Pass       (Pass),
    .Status     (Status),
    .StoreCount (StoreCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] adr);
    return (adr < TB_DEPTH * 4) && (adr % 4 == 0);
  endfunction

  task automatic check_read(input string tag, input logic [31:0] adr);
    int unsigned w;
    w = adr / 4;
    if (!addr_ok(adr)) check_eq(tag, ReadData, 32'h0);
    else if (m_known[w]) check_eq(tag, ReadData, m_mem[w]);
  endtask

  task automatic model_edge(input logic rst, input logic we,
                            input logic [31:0] adr, input logic [31:0] wd);
    if (we && addr_ok(adr)) begin
      m_mem[adr / 4]   = wd;
      m_known[adr / 4] = 1'b1;
    end
    if (rst) begin
      m_status    = 0;
      m_run_edges = 0;
      m_stores    = 0;
    end else if (m_status == 0) begin
      if (we && m_stores < 65535) m_stores++;
      if (we && adr == 100 && wd == 7) m_status = 1;
      else if (we && adr != 96) m_status = 2;
      else if (m_run_edges + 1 == TB_TIMEOUT) m_status = 3;
      m_run_edges++;
    end
  endtask

  // One clock: drive at negedge, check the load before the edge, check all after.
  task automatic cyc(input logic rst, input logic we,
                     input logic [31:0] adr, input logic [31:0] wd);
    reset = rst; MemWrite = we; DataAdr = adr; WriteData = wd;
    #1;
    check_read("rd_pre", adr);
    @(posedge clk);
    model_edge(rst, we, adr, wd);
    @(negedge clk);
    check_eq("status", 32'(Status), 32'(m_status));
    check_eq("done", 32'(Done), 32'(m_status != 0));
    check_eq("pass", 32'(Pass), 32'(m_status == 1));
    check_eq("count", 32'(StoreCount), 32'(m_stores));
    check_read("rd_post", adr);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_adr();
    int unsigned p;
    logic [5:0] w;
    p = $urandom_range(0, 99);
    w = 6'($urandom_range(0, 63));
    if (p < 35) return 32'd96;
    if (p < 50) return 32'd100;
    if (p < 80) return {24'd0, w, 2'b00};
    if (p < 90) return 32'h0000_0800 | {24'd0, w, 2'b00};
    return {24'd0, w, 2'($urandom_range(1, 3))};
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    int n;
    checks = 0; failures = 0;
    m_status = 0; m_run_edges = 0; m_stores = 0;
    for (int i = 0; i < TB_DEPTH; i++) begin
      m_mem[i] = '0;
      m_known[i] = 1'b0;
    end
    reset = 1'b1; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
    @(negedge clk);

    // Bring up and give every RAM word a known value.
    do_reset(2);
    for (int i = 0; i < TB_DEPTH; i++) cyc(1'b0, 1'b1, 32'(i * 4), $urandom());

    // Scratch store then passing store.
    do_reset(3);
    check_eq("rst_status", 32'(Status), 32'h0);
    check_eq("rst_count", 32'(StoreCount), 32'h0);
    cyc(1'b0, 1'b1, 32'd96, 32'd5);
    cyc(1'b0, 1'b1, 32'd100, 32'd7);
    check_eq("pass_done", 32'(Done), 32'h1);
    check_eq("pass_pass", 32'(Pass), 32'h1);
    check_eq("pass_status", 32'(Status), 32'h1);
    check_eq("pass_count", 32'(StoreCount), 32'h2);

    // Reset from PASS; RAM survives.
    cyc(1'b1, 1'b0, 32'd100, 32'h0);
    check_eq("rst_pass_status", 32'(Status), 32'h0);
    check_eq("rst_pass_count", 32'(StoreCount), 32'h0);
    check_eq("rst_pass_ram25", ReadData, 32'd7);

    // Wrong pass data fails and stays failed.
    do_reset(1);
    cyc(1'b0, 1'b1, 32'd100, 32'd6);
    check_eq("wrong_status", 32'(Status), 32'h2);
    check_eq("wrong_pass", 32'(Pass), 32'h0);
    cyc(1'b0, 1'b1, 32'd100, 32'd7);
    check_eq("sticky_status", 32'(Status), 32'h2);
    check_eq("sticky_count", 32'(StoreCount), 32'h1);

    // Illegal store address fails; RAM still written; out-of-range reads zero.
    do_reset(1);
    cyc(1'b0, 1'b1, 32'd104, 32'd1);
    check_eq("ill_status", 32'(Status), 32'h2);
    cyc(1'b0, 1'b0, 32'd104, 32'h0);
    check_eq("ill_rd104", ReadData, 32'd1);
    cyc(1'b0, 1'b0, 32'd2048, 32'h0);
    check_eq("ill_rd2048", ReadData, 32'h0);

    // Watchdog fires on the TIMEOUT-th RUN edge.
    do_reset(1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 32'd0, 32'h0);
    check_eq("wd_15", 32'(Status), 32'h0);
    cyc(1'b0, 1'b0, 32'd0, 32'h0);
    check_eq("wd_16", 32'(Status), 32'h3);

    // A passing store on the expiry edge wins.
    do_reset(1);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 32'd0, 32'h0);
    cyc(1'b0, 1'b1, 32'd100, 32'd7);
    check_eq("wd_race", 32'(Status), 32'h1);

    // Scratch store/load round trip.
    do_reset(1);
    cyc(1'b0, 1'b1, 32'd96, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, 32'd96, 32'h0);
    check_eq("scr_rd", ReadData, 32'hDEAD_BEEF);
    check_eq("scr_status", 32'(Status), 32'h0);

    // Randomized traffic including stores during reset and mid-run resets.
    for (int s = 0; s < 60; s++) begin
      a = rand_adr();
      cyc(1'b1, 1'($urandom_range(0, 1)), a, $urandom());
      n = $urandom_range(4, 24);
      for (int c = 0; c < n; c++) begin
        a = rand_adr();
        d = (a == 32'd100 && $urandom_range(0, 1) == 1) ? 32'd7 : $urandom();
        cyc(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) == 0), a, d);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_monitor.md
DMEM_MONITOR -- requirements
Module: dmem_monitor

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning data RAM size in 32-bit words (power of two).
REQ-002 The block SHALL have parameter PASS_ADR, default 100, meaning byte address whose store decides success.
REQ-003 The block SHALL have parameter PASS_DATA, default 7, meaning the value at PASS_ADR that signals success.
REQ-004 The block SHALL have parameter SCRATCH_ADR, default 96, meaning the only other byte address the program may store to.
REQ-005 The block SHALL have parameter TIMEOUT, default 1024, meaning cycles in RUN before the watchdog fires.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port MemWrite, input, 1 bit: store strobe from the CPU.
REQ-009 The block SHALL have port DataAdr, input, 32 bits: byte address from the CPU.
REQ-010 The block SHALL have port WriteData, input, 32 bits: store data from the CPU.
REQ-011 The block SHALL have port ReadData, output, 32 bits: load data to the CPU.
REQ-012 The block SHALL have port Done, output, 1 bit: high once the monitor leaves RUN.
REQ-013 The block SHALL have port Pass, output, 1 bit: high only in PASS.
REQ-014 The block SHALL have port Status, output, 2 bits: encoding RUN=00, PASS=01, FAIL=10, TIMEOUT=11.
REQ-015 The block SHALL have port StoreCount, output, 16 bits: number of stores accepted while in RUN.

Function
REQ-016 Word index SHALL be DataAdr[log2(DEPTH)+1:2]; an address is in range iff all bits above that field and DataAdr[1:0] are zero.
REQ-017 ReadData SHALL be combinational: RAM[index] when in range, 32'h0 otherwise.
REQ-018 On a rising edge with MemWrite=1 and in-range address, RAM[index] SHALL take WriteData; out-of-range stores SHALL not modify RAM.
REQ-019 A load from the address just stored SHALL return the new data from the following cycle, with no forwarding in the store cycle.
REQ-020 The state machine SHALL have states RUN, PASS, FAIL and TIMEOUT.
REQ-021 In RUN, a store with DataAdr==PASS_ADR and WriteData==PASS_DATA SHALL move the state to PASS at that edge.
REQ-022 In RUN, any other store with DataAdr!=SCRATCH_ADR, including PASS_ADR with wrong data, SHALL move the state to FAIL.
REQ-023 In RUN, a store to SCRATCH_ADR SHALL leave the state in RUN.
REQ-024 The watchdog counter SHALL increment every RUN cycle; when it equals TIMEOUT-1 with no terminal store on that edge, the state SHALL move to TIMEOUT.
REQ-025 When a store decision and watchdog expiry coincide, the store decision SHALL win.
REQ-026 PASS, FAIL and TIMEOUT SHALL be sticky until reset; RAM stores SHALL still be performed in them.
REQ-027 StoreCount SHALL increment on each MemWrite edge while in RUN, including the deciding store, saturate at 16'hFFFF, and freeze outside RUN.
REQ-028 Done, Pass and Status SHALL be decoded only from the state register, never directly from the inputs.

Reset
REQ-029 While reset=1 at an edge: state SHALL become RUN, the watchdog and StoreCount SHALL become 0, and stores SHALL be ignored by the state machine.
REQ-030 After reset, outputs SHALL be Done=0, Pass=0, Status=00, StoreCount=0.
REQ-031 RAM contents SHALL not be reset, and ReadData SHALL follow RAM even during reset.
REQ-032 Reset asserted mid-run or in a terminal state SHALL return to RUN at the next edge, restarting the watchdog from 0.

Structure
REQ-033 Package dmem_monitor_pkg SHALL hold the state enum, Status encodings and default parameter constants.
REQ-034 The RAM (async read, sync write, no reset) SHALL be the sub-module dmem_ram; the FSM, watchdog and counter SHALL stay in dmem_monitor.

Verification
REQ-035 Reset 3 cycles, then store (96,5), then (100,7) -> after the second edge Done=1, Pass=1, Status=01, StoreCount=2.
REQ-036 Store (100,6) -> Status=10 and Pass=0; a later (100,7) -> Status stays 10 and StoreCount stays 1.
REQ-037 Store (104,1) -> FAIL; ReadData at address 104 = 1 on the next cycle, and address 2048 reads 0.
REQ-038 No stores with TIMEOUT=16 -> Status=11 exactly 16 edges after reset release; with (100,7) on edge 16 -> Status=01 instead.
REQ-039 Reach PASS, then assert reset for 1 cycle -> Status=00, StoreCount=0; RAM word 25 still reads 7.
REQ-040 Store (96,32'hDEADBEEF) then load 96 -> ReadData=32'hDEADBEEF, and Status stays 00.
